// File: rtl/poly_voice_mixer.sv
// poly_voice_mixer: N-voice synthesiser core feeding the PWM DAC.
// Each voice has a phase accumulator, a selectable waveform and a linear
// attack/release envelope. A Galois LFSR adds a noise channel. All channels
// are summed in a two-stage registered pipeline, shifted and saturated to
// an unsigned PCM word.
//
// Interface timing: there is no valid/ready handshake. A new sample is
// produced every clock. pcm/clip at cycle k+2 reflect the accumulator,
// envelope level and LFSR state present at cycle k.
module poly_voice_mixer #(
    parameter int NUM_VOICES = 4,
    parameter int ACC_W      = 28,
    parameter int INC_W      = 19,
    parameter int ENV_DIV    = 4096,
    parameter int MIX_SHIFT  = 2,
    parameter int OUT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_VOICES*INC_W-1:0]   increment,
    input  logic [NUM_VOICES-1:0]         gate,
    input  logic [2*NUM_VOICES-1:0]       wave_sel,
    input  logic [4*NUM_VOICES-1:0]       volume,
    input  logic [NUM_VOICES-1:0]         sync,
    input  logic [3:0]                    noise_vol,
    output logic [OUT_W-1:0]              pcm,
    output logic                          clip
);

    // Sum width is sized so that NUM_VOICES 16-bit products plus the 16-bit
    // noise term can never overflow before the shift.
    localparam int SUM_W  = 16 + $clog2(NUM_VOICES + 1);
    localparam int WIDE_W = (SUM_W > OUT_W) ? SUM_W : OUT_W;
    localparam int DIV_W  = $clog2(ENV_DIV);

    localparam logic [1:0] WAVE_SAW      = 2'd0;
    localparam logic [1:0] WAVE_PULSE    = 2'd1;
    localparam logic [1:0] WAVE_TRIANGLE = 2'd2;

    logic [ACC_W-1:0]  acc       [NUM_VOICES];
    logic [7:0]        level     [NUM_VOICES];
    logic [7:0]        level_nxt [NUM_VOICES];
    logic [7:0]        env_target[NUM_VOICES];
    logic [7:0]        wave      [NUM_VOICES];
    logic [7:0]        tri_ramp  [NUM_VOICES];
    logic [15:0]       prod      [NUM_VOICES];
    logic [DIV_W-1:0]  div_cnt;
    logic              tick;
    logic [15:0]       lfsr;
    logic [15:0]       noise_mul;
    logic [15:0]       noise_p;
    logic [SUM_W-1:0]  sum_raw;
    logic [SUM_W-1:0]  sum_shift;
    logic [WIDE_W-1:0] sum_wide;
    logic              sat;

    assign tick = (div_cnt == DIV_W'(ENV_DIV - 1));

    // Phase accumulators: free-running add, sync forces the phase to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VOICES; v++) acc[v] <= '0;
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (sync[v]) acc[v] <= '0;
                else         acc[v] <= acc[v] + ACC_W'(increment[v*INC_W +: INC_W]);
            end
        end
    end

    // Waveform selection from the top bits of each accumulator.
    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            tri_ramp[v] = {acc[v][ACC_W-2 -: 7], 1'b0};
            wave[v]     = 8'd0;
            case (wave_sel[2*v +: 2])
                WAVE_SAW:      wave[v] = acc[v][ACC_W-1 -: 8];
                WAVE_PULSE:    wave[v] = acc[v][ACC_W-1] ? 8'd0 : 8'd255;
                WAVE_TRIANGLE: wave[v] = acc[v][ACC_W-1] ? ~tri_ramp[v] : tri_ramp[v];
                default:       wave[v] = 8'd0;
            endcase
        end
    end

    // Envelope divider: one tick every ENV_DIV clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 1'b1;
    end

    // Envelope next level: step toward target while gated, decay to zero when not.
    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            env_target[v] = {volume[4*v +: 4], volume[4*v +: 4]};
            level_nxt[v]  = level[v];
            if (tick) begin
                if (gate[v]) begin
                    if (level[v] < env_target[v])      level_nxt[v] = level[v] + 8'd1;
                    else if (level[v] > env_target[v]) level_nxt[v] = level[v] - 8'd1;
                end else if (level[v] != 8'd0) begin
                    level_nxt[v] = level[v] - 8'd1;
                end
            end
        end
    end

    // Envelope level registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VOICES; v++) level[v] <= 8'd0;
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) level[v] <= level_nxt[v];
        end
    end

    // Noise source: 16-bit Galois LFSR, taps 16'hB400.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr <= 16'hACE1;
        else        lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    // Noise scaling: at most 255*15 = 3825, so the <<4 still fits 16 bits.
    assign noise_mul = 16'(lfsr[7:0]) * 16'(noise_vol);

    // Pipeline stage 1: per-voice product of waveform and envelope, plus noise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VOICES; v++) prod[v] <= 16'd0;
            noise_p <= 16'd0;
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) prod[v] <= 16'(wave[v]) * 16'(level[v]);
            noise_p <= noise_mul << 4;
        end
    end

    // Mix: full-width sum, shift, then detect values beyond the PCM range.
    always_comb begin
        sum_raw = SUM_W'(noise_p);
        for (int v = 0; v < NUM_VOICES; v++) sum_raw = sum_raw + SUM_W'(prod[v]);
        sum_shift = sum_raw >> MIX_SHIFT;
        sum_wide  = WIDE_W'(sum_shift);
        sat       = (sum_wide > WIDE_W'({OUT_W{1'b1}}));
    end

    // Pipeline stage 2: saturated PCM word and clip flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcm  <= '0;
            clip <= 1'b0;
        end else begin
            pcm  <= sat ? {OUT_W{1'b1}} : OUT_W'(sum_wide);
            clip <= sat;
        end
    end

endmodule

// File: tb/tb_poly_voice_mixer.sv
// tb_poly_voice_mixer: directed bench for poly_voice_mixer. Two instances
// share every input: dut uses MIX_SHIFT=2, dut0 uses MIX_SHIFT=0, both with
// ENV_DIV=4 so envelopes move quickly.
module tb_poly_voice_mixer;

    localparam int NV    = 4;
    localparam int INC_W = 19;

    // Clock/reset block.
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NV*INC_W-1:0] increment = '0;
    logic [NV-1:0]       gate      = '0;
    logic [2*NV-1:0]     wave_sel  = '1;
    logic [4*NV-1:0]     volume    = '0;
    logic [NV-1:0]       sync      = '0;
    logic [3:0]          noise_vol = '0;
    logic [15:0]         pcm, pcm0;
    logic                clip, clip0;

    poly_voice_mixer #(.NUM_VOICES(NV), .ACC_W(28), .INC_W(INC_W), .ENV_DIV(4),
                       .MIX_SHIFT(2), .OUT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .increment(increment), .gate(gate),
        .wave_sel(wave_sel), .volume(volume), .sync(sync), .noise_vol(noise_vol),
        .pcm(pcm), .clip(clip));

    poly_voice_mixer #(.NUM_VOICES(NV), .ACC_W(28), .INC_W(INC_W), .ENV_DIV(4),
                       .MIX_SHIFT(0), .OUT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .increment(increment), .gate(gate),
        .wave_sel(wave_sel), .volume(volume), .sync(sync), .noise_vol(noise_vol),
        .pcm(pcm0), .clip(clip0));

    // Scoreboard counters.
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       name;
        logic [31:0] tops;    // accumulator top byte per voice, voice0 in [7:0]
        logic [7:0]  wsel;
        logic [15:0] pcm_s2;  // expected pcm with MIX_SHIFT=2
        logic [15:0] pcm_s0;  // expected pcm with MIX_SHIFT=0
        logic        clip_s0;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Driver: advance n clocks, ending just after a falling edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Driver: hold reset for a few cycles and release it on a falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
    endtask

    // Driver: per-voice increments of top*2048, so 512 clocks land acc on top<<20.
    task automatic set_inc(input logic [31:0] tops);
        for (int v = 0; v < NV; v++)
            increment[v*INC_W +: INC_W] = 19'(tops[8*v +: 8]) << 11;
    endtask

    // Watchdog.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Vectors: all voices at level 255, so each product is wave*255.
        vecs[0] = '{"sat_all_pulse",  32'h0000_0000, 8'h55, 16'd65025, 16'hFFFF, 1'b1};
        vecs[1] = '{"saw_only",       32'h0000_0040, 8'hFC, 16'd4080,  16'd16320, 1'b0};
        vecs[2] = '{"mixed_tri",      32'hFF80_C040, 8'h1A, 16'd32512, 16'hFFFF, 1'b1};
        vecs[3] = '{"just_over",      32'h0110_7F01, 8'hB4, 16'd16447, 16'hFFFF, 1'b1};
        vecs[4] = '{"saw_saw_tri",    32'h00FF_0181, 8'hE0, 16'd8351,  16'd33405, 1'b0};
        vecs[5] = '{"exact_max",      32'h0000_01FF, 8'hF8, 16'd16383, 16'hFFFF, 1'b0};

        // Reset with toggling inputs.
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            increment = {$urandom, $urandom, $urandom};
            gate      = NV'($urandom_range(0, 15));
            wave_sel  = 8'($urandom_range(0, 255));
            volume    = 16'($urandom_range(0, 65535));
            sync      = NV'($urandom_range(0, 15));
            noise_vol = 4'($urandom_range(0, 15));
            step(1);
            check("reset_pcm", pcm, 0);
            check("reset_clip", clip, 0);
        end
        check("reset_level0", dut.level[0], 0);
        check("reset_level3", dut.level[3], 0);
        gate = '0; noise_vol = '0; sync = '0;
        rst_n = 1'b1;
        step(2);
        check("post_reset_pcm", pcm, 0);
        check("post_reset_pcm0", pcm0, 0);

        // Noise channel alone.
        increment = '0; wave_sel = 8'hFF; volume = '0; noise_vol = 4'd15;
        do_reset();
        step(1);
        check("lfsr_first", dut.lfsr, 16'hE270);
        step(2);
        check("noise_pcm0", pcm0, 26880);
        check("noise_pcm", pcm, 6720);
        noise_vol = 4'd0;
        step(2);
        check("noise_off_pcm0", pcm0, 0);

        // Attack/release on voice0 (pulse at phase 0 gives 255), others silent.
        wave_sel = 8'hFD; volume = 16'h000F; gate = 4'b0001;
        do_reset();
        step(1019);
        check("attack_254", dut.level[0], 254);
        step(1);
        check("attack_255", dut.level[0], 255);
        step(8);
        check("attack_hold", dut.level[0], 255);
        check("attack_pcm", pcm, 16256);
        check("attack_pcm0", pcm0, 65025);
        check("attack_clip0", clip0, 0);
        gate = 4'b0000;
        step(1019);
        check("release_1", dut.level[0], 1);
        step(1);
        check("release_0", dut.level[0], 0);
        step(2);
        check("release_pcm", pcm0, 0);

        // Table: all levels at 255, accumulators parked at chosen phases.
        wave_sel = 8'h55; volume = 16'hFFFF; gate = 4'hF;
        do_reset();
        step(1024);
        check("all_level3", dut.level[3], 255);
        for (int k = 0; k < 6; k++) begin
            wave_sel = vecs[k].wsel;
            set_inc(vecs[k].tops);
            sync = 4'hF;
            step(1);
            check({vecs[k].name, "_sync"}, dut.acc[0], 0);
            sync = 4'h0;
            step(512);
            increment = '0;
            check({vecs[k].name, "_acc"}, dut.acc[0], {vecs[k].tops[7:0], 20'd0});
            step(2);
            check({vecs[k].name, "_pcm"}, pcm, vecs[k].pcm_s2);
            check({vecs[k].name, "_clip"}, clip, 0);
            check({vecs[k].name, "_pcm0"}, pcm0, vecs[k].pcm_s0);
            check({vecs[k].name, "_clip0"}, clip0, vecs[k].clip_s0);
        end

        // Retarget: volume 8 -> target 136, one step per tick.
        volume = 16'h8888;
        step(4);
        check("retarget_254", dut.level[0], 254);
        step(4);
        check("retarget_253", dut.level[0], 253);
        step(600);
        check("retarget_136", dut.level[0], 136);
        step(40);
        check("retarget_hold", dut.level[2], 136);

        // Reset mid-note: immediate silence, re-attack from zero.
        wave_sel = 8'h55;
        rst_n = 1'b0;
        #1;
        check("midreset_pcm0", pcm0, 0);
        check("midreset_level", dut.level[0], 0);
        step(2);
        rst_n = 1'b1;
        step(2);
        check("reattack_pcm_quiet", pcm0, 0);
        step(2);
        check("reattack_level", dut.level[1], 1);
        step(2);
        check("reattack_pcm0", pcm0, 1020);
        check("reattack_pcm", pcm, 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
